// File: rtl/axi_lite_sram.sv
// axi_lite_sram
//   Word-addressed AXI-lite slave memory for the LSU data port. The read channel
//   (AR/R) and the write channel (AW/W/B) are two independent FSMs that share one
//   32-bit word array. Each FSM has a programmable latency.
//
// Ports
//   clk, rst                        clock and asynchronous active-high reset
//   araddr/arvalid/arready          read address channel
//   rdata/rresp/rvalid/rready       read data channel (00 OKAY, 11 DECERR)
//   awaddr/awvalid/awready          write address channel
//   wdata/wstrb/wvalid/wready       write data channel (already lane-shifted)
//   bresp/bvalid/bready             write response channel (00 OKAY, 11 DECERR)
//
// The array itself is never reset. Reset only returns both FSMs to idle, so a
// write that has not yet committed is lost.
module axi_lite_sram #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 1024,
    parameter int          RD_LAT = 1,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = 8;
    localparam logic [31:0] LIMIT   = BASE + 32'(4 * DEPTH);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    // Byte offset from BASE, word index; addr[1:0] are dropped by the shift.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    logic [31:0] mem [DEPTH];

    // ---------------- read path ----------------
    logic [1:0]    r_state_q, r_state_d;
    logic [CW-1:0] r_cnt_q,   r_cnt_d;
    logic [31:0]   r_addr_q,  r_addr_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic [1:0]    rresp_q,   rresp_d;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_addr_d  = r_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_addr_d  = araddr;
                    r_cnt_d   = RD_LOAD;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    // Samples the array before any same-edge write commit lands,
                    // so a colliding read sees the old word.
                    if (in_range(r_addr_q)) begin
                        rdata_d = mem[word_idx(r_addr_q)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - CW'(1);
                end
            end
            R_RESP: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // ---------------- write path ----------------
    logic [1:0]    w_state_q, w_state_d;
    logic [CW-1:0] w_cnt_q,   w_cnt_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q,  w_held_d;
    logic [31:0]   w_addr_q,  w_addr_d;
    logic [31:0]   w_data_q,  w_data_d;
    logic [3:0]    w_strb_q,  w_strb_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic          mem_we;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                // Each channel is captured exactly once, in either order.
                if (awvalid && !aw_held_q) begin
                    w_addr_d  = awaddr;
                    aw_held_d = 1'b1;
                end
                if (wvalid && !w_held_q) begin
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                    w_held_d = 1'b1;
                end
                if ((aw_held_q || awvalid) && (w_held_q || wvalid)) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_cnt_d   = WR_LOAD;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) begin
                    mem_we    = in_range(w_addr_q);
                    bresp_d   = in_range(w_addr_q) ? RESP_OKAY : RESP_DECERR;
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - CW'(1);
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-lane commit; lanes with a clear strobe keep their old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
    end

    assign awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign wready  = (w_state_q == W_IDLE) && !w_held_q;
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
module tb_axi_lite_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // Second instance with RD_LAT=3 shares all inputs except rready.
    logic        r3_arready;
    logic [31:0] r3_rdata;
    logic [1:0]  r3_rresp;
    logic        r3_rvalid;
    logic        r3_rready;
    logic        r3_awready;
    logic        r3_wready;
    logic [1:0]  r3_bresp;
    logic        r3_bvalid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] wr_q[$];

    always #5 clk = ~clk;

    axi_lite_sram #(.RD_LAT(1), .WR_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_lite_sram #(.RD_LAT(3), .WR_LAT(1)) u_dut3 (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(r3_arready),
        .rdata(r3_rdata), .rresp(r3_rresp), .rvalid(r3_rvalid), .rready(r3_rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(r3_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(r3_wready),
        .bresp(r3_bresp), .bvalid(r3_bvalid), .bready(bready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a response handshake is pending.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid && rready) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got rdata %h with no read outstanding", rdata);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", 32'(rresp), 32'(e.resp));
                end
            end
            if (bvalid && bready) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got bresp %b with no write outstanding", bresp);
                end else begin
                    logic [1:0] eb;
                    eb = wr_q.pop_front();
                    check("bresp", 32'(bresp), 32'(eb));
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int n;
        rd_q.push_back({exp_r, exp_d});
        araddr  = addr;
        arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("arready_busy", 32'(arready), 32'd0);
        end while (!rvalid && n < 20);
        check("rd_latency", 32'(n), 32'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input logic [1:0] exp_b);
        int n;
        int last;
        wr_q.push_back(exp_b);
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int c = 0; c <= last; c++) begin
            if (c > aw_dly) check("awready_held", 32'(awready), 32'd0);
            if (c > w_dly)  check("wready_held", 32'(wready), 32'd0);
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = (c == aw_dly);
            wvalid  = (c == w_dly);
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bvalid && n < 20);
        check("wr_latency", 32'(n), 32'd2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1; r3_rready = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd1);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        check("rst_r3_ready", 32'({r3_arready, r3_awready, r3_wready}), 32'd7);
        check("rst_r3_valid", 32'({r3_rvalid, r3_bvalid, r3_bresp}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload known words through the bus
        do_write(32'h8000_0000, 32'h0000_0000, 4'hF, 0, 0, 2'b00);
        do_write(32'h8000_0004, 32'h1122_3344, 4'hF, 0, 0, 2'b00);
        do_write(32'h8000_0008, 32'h0000_0000, 4'hF, 0, 0, 2'b00);
        do_write(32'h8000_000C, 32'h3333_3333, 4'hF, 0, 0, 2'b00);
        do_write(32'h8000_0014, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00);
        do_write(32'h8000_0FFC, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00);

        // First read of word 0
        do_read(32'h8000_0000, 32'h0000_0000, 2'b00);

        // AW then W two cycles later, partial strobe
        do_write(32'h8000_0004, 32'hA1B2_C3D4, 4'b0110, 0, 2, 2'b00);
        do_read(32'h8000_0004, 32'h11B2_C344, 2'b00);

        // W before AW, single byte lane
        do_write(32'h8000_0008, 32'h5566_77AB, 4'b0001, 1, 0, 2'b00);
        do_read(32'h8000_0008, 32'h0000_00AB, 2'b00);

        // Zero strobe: OKAY, no change; low address bits ignored on readback
        do_write(32'h8000_0004, 32'hFFFF_FFFF, 4'b0000, 0, 0, 2'b00);
        do_read(32'h8000_0007, 32'h11B2_C344, 2'b00);

        // Out-of-range on both sides of the window
        do_read(32'h7FFF_FFFC, 32'h0000_0000, 2'b11);
        do_write(32'h8000_1000, 32'h1234_5678, 4'hF, 0, 0, 2'b11);
        do_read(32'h8000_1000, 32'h0000_0000, 2'b11);
        do_read(32'h8000_0FFC, 32'hDEAD_BEEF, 2'b00);

        // Same-cycle write commit and read sample on word 0
        rd_q.push_back({2'b00, 32'h0000_0000});
        wr_q.push_back(2'b00);
        araddr = 32'h8000_0000; awaddr = 32'h8000_0000;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_read(32'h8000_0000, 32'hFFFF_FFFF, 2'b00);

        // RD_LAT=3 instance with read back-pressure; main instance also answers
        repeat (8) @(posedge clk);
        #1 r3_rready = 1'b0;
        rd_q.push_back({2'b00, 32'hCAFE_F00D});
        araddr  = 32'h8000_0014;
        arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("r3_arready_wait", 32'(r3_arready), 32'd0);
        end while (!r3_rvalid && n < 20);
        check("r3_latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("r3_rvalid_hold", 32'(r3_rvalid), 32'd1);
            check("r3_rdata_hold",  r3_rdata,       32'hCAFE_F00D);
            check("r3_arready_hold", 32'(r3_arready), 32'd0);
        end
        check("r3_rresp", 32'(r3_rresp), 32'd0);
        @(posedge clk);
        #1 r3_rready = 1'b1;
        @(posedge clk);
        #1;
        check("r3_arready_after", 32'(r3_arready), 32'd1);
        check("r3_rvalid_after",  32'(r3_rvalid),  32'd0);

        // Reset pulse while both FSMs wait: nothing completes, write to word 3 lost
        repeat (6) @(posedge clk);
        #1;
        araddr = 32'h8000_0000; awaddr = 32'h8000_000C;
        wdata = 32'h0000_0000; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("prst_arready", 32'(arready), 32'd1);
        check("prst_awready", 32'(awready), 32'd1);
        check("prst_wready",  32'(wready),  32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("prst_rvalid", 32'(rvalid), 32'd0);
            check("prst_bvalid", 32'(bvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        do_read(32'h8000_000C, 32'h3333_3333, 2'b00);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
